axil_order_sequencer: RTL and testbench



---
 rtl/order_seq_pkg.sv | 25 ++
 rtl/order_fifo.sv | 55 +++++
 rtl/axil_order_sequencer.sv | 225 ++++++++++++++++++++++
 tb/tb_axil_order_sequencer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/order_seq_pkg.sv
// Shared types for the AXI-lite order sequencer: order word layout, FSM
// states and the OKAY response code.
package order_seq_pkg;

    localparam int ORD_ADDR_W = 8;
    localparam int ORD_DATA_W = 32;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef struct packed {
        logic [ORD_ADDR_W-1:0] addr;
        logic [ORD_DATA_W-1:0] data;
        logic                  last;
    } order_t;

    typedef enum logic [2:0] {
        IDLE,
        POLL_AR,
        POLL_R,
        POLL_WAIT,
        WR_REQ,
        WR_RESP
    } seq_state_e;

endpackage

// File: rtl/order_fifo.sv
// Order buffer: synchronous FIFO with an extra pointer wrap bit for full/empty.
// The head is read from registered pointers, so a word pushed into an empty FIFO
// becomes visible one cycle later.
module order_fifo
    import order_seq_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push,
    input  order_t wr_data,
    input  logic   pop,
    output order_t rd_data,
    output logic   full,
    output logic   empty
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    order_t           mem_q [FIFO_DEPTH];
    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
    logic             push_ok, pop_ok;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rd_data = mem_q[rd_ptr_q[PTR_W-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset; validity is tracked entirely by the pointers.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[PTR_W-1:0]] <= wr_data;
    end

endmodule

// File: rtl/axil_order_sequencer.sv
// AXI-lite master replaying buffered address/data orders into the core's
// configuration slave; writes to the launch register wait for a non-zero status.
module axil_order_sequencer
    import order_seq_pkg::*;
#(
    parameter int                         AXIL_DATA_WIDTH = 32,
    parameter int                         AXIL_ADDR_WIDTH = 8,
    parameter int                         FIFO_DEPTH      = 16,
    parameter logic [AXIL_ADDR_WIDTH-1:0] GATE_ADDR       = 8'h48,
    parameter logic [AXIL_ADDR_WIDTH-1:0] STATUS_ADDR     = 8'h4c,
    parameter int                         POLL_GAP        = 4
) (
    input  logic                         m00_axi_aclk,
    input  logic                         m00_axi_aresetn,

    input  logic                         ord_valid,
    output logic                         ord_ready,
    input  logic [AXIL_ADDR_WIDTH-1:0]   ord_addr,
    input  logic [AXIL_DATA_WIDTH-1:0]   ord_data,
    input  logic                         ord_last,

    output logic [AXIL_ADDR_WIDTH-1:0]   m00_axi_awaddr,
    output logic [2:0]                   m00_axi_awprot,
    output logic                         m00_axi_awvalid,
    input  logic                         m00_axi_awready,
    output logic [AXIL_DATA_WIDTH-1:0]   m00_axi_wdata,
    output logic [AXIL_DATA_WIDTH/8-1:0] m00_axi_wstrb,
    output logic                         m00_axi_wvalid,
    input  logic                         m00_axi_wready,
    input  logic [1:0]                   m00_axi_bresp,
    input  logic                         m00_axi_bvalid,
    output logic                         m00_axi_bready,
    output logic [AXIL_ADDR_WIDTH-1:0]   m00_axi_araddr,
    output logic [2:0]                   m00_axi_arprot,
    output logic                         m00_axi_arvalid,
    input  logic                         m00_axi_arready,
    input  logic [AXIL_DATA_WIDTH-1:0]   m00_axi_rdata,
    input  logic [1:0]                   m00_axi_rresp,
    input  logic                         m00_axi_rvalid,
    output logic                         m00_axi_rready,

    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic [AXIL_ADDR_WIDTH-1:0]   err_addr,
    output logic [15:0]                  ord_count
);

    localparam int CNT_W = (POLL_GAP > 1) ? $clog2(POLL_GAP + 1) : 1;

    seq_state_e                 state_q, state_d;
    order_t                     cur_q, cur_d;
    logic                       awvalid_q, awvalid_d;
    logic                       wvalid_q, wvalid_d;
    logic                       arvalid_q, arvalid_d;
    logic                       rready_q, rready_d;
    logic                       bready_q, bready_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic                       err_q, err_d;
    logic [AXIL_ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
    logic [15:0]                ord_count_q, ord_count_d;
    logic                       done_q, done_d;
    logic                       out_of_reset_q;

    order_t fifo_in, fifo_head;
    logic   fifo_full, fifo_empty, fifo_pop;

    assign fifo_in.addr = ord_addr;
    assign fifo_in.data = ord_data;
    assign fifo_in.last = ord_last;

    // Held low through reset and released on the first clock after it.
    assign ord_ready = out_of_reset_q && !fifo_full;

    order_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (m00_axi_aclk),
        .rst_n   (m00_axi_aresetn),
        .push    (ord_valid && ord_ready),
        .wr_data (fifo_in),
        .pop     (fifo_pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        bready_d    = bready_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        err_addr_d  = err_addr_q;
        ord_count_d = ord_count_q;
        done_d      = 1'b0;
        fifo_pop    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    cur_d    = fifo_head;
                    if (fifo_head.addr == GATE_ADDR) begin
                        state_d   = POLL_AR;
                        arvalid_d = 1'b1;
                    end else begin
                        state_d   = WR_REQ;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end
                end
            end
            POLL_AR: begin
                if (m00_axi_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = POLL_R;
                end
            end
            POLL_R: begin
                if (m00_axi_rvalid) begin
                    rready_d = 1'b0;
                    if (m00_axi_rresp != RESP_OKAY) begin
                        err_d = 1'b1;
                        if (!err_q) err_addr_d = STATUS_ADDR;
                    end
                    // A failed status read counts as "not ready" and keeps polling.
                    if (m00_axi_rdata != '0 && m00_axi_rresp == RESP_OKAY) begin
                        state_d   = WR_REQ;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d = POLL_WAIT;
                        cnt_d   = CNT_W'(POLL_GAP);
                    end
                end
            end
            POLL_WAIT: begin
                if (cnt_q == '0) begin
                    state_d   = POLL_AR;
                    arvalid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            WR_REQ: begin
                if (m00_axi_awready) awvalid_d = 1'b0;
                if (m00_axi_wready)  wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    state_d  = WR_RESP;
                    bready_d = 1'b1;
                end
            end
            WR_RESP: begin
                if (m00_axi_bvalid) begin
                    bready_d    = 1'b0;
                    ord_count_d = ord_count_q + 16'd1;
                    if (m00_axi_bresp != RESP_OKAY) begin
                        err_d = 1'b1;
                        if (!err_q) err_addr_d = cur_q.addr;
                    end
                    done_d  = cur_q.last;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
        if (!m00_axi_aresetn) begin
            state_q        <= IDLE;
            cur_q          <= '0;
            awvalid_q      <= 1'b0;
            wvalid_q       <= 1'b0;
            arvalid_q      <= 1'b0;
            rready_q       <= 1'b0;
            bready_q       <= 1'b0;
            cnt_q          <= '0;
            err_q          <= 1'b0;
            err_addr_q     <= '0;
            ord_count_q    <= '0;
            done_q         <= 1'b0;
            out_of_reset_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cur_q          <= cur_d;
            awvalid_q      <= awvalid_d;
            wvalid_q       <= wvalid_d;
            arvalid_q      <= arvalid_d;
            rready_q       <= rready_d;
            bready_q       <= bready_d;
            cnt_q          <= cnt_d;
            err_q          <= err_d;
            err_addr_q     <= err_addr_d;
            ord_count_q    <= ord_count_d;
            done_q         <= done_d;
            out_of_reset_q <= 1'b1;
        end
    end

    assign m00_axi_awaddr  = cur_q.addr;
    assign m00_axi_awprot  = 3'b000;
    assign m00_axi_awvalid = awvalid_q;
    assign m00_axi_wdata   = cur_q.data;
    assign m00_axi_wstrb   = '1;
    assign m00_axi_wvalid  = wvalid_q;
    assign m00_axi_bready  = bready_q;
    assign m00_axi_araddr  = STATUS_ADDR;
    assign m00_axi_arprot  = 3'b000;
    assign m00_axi_arvalid = arvalid_q;
    assign m00_axi_rready  = rready_q;

    assign busy      = !fifo_empty || (state_q != IDLE);
    assign done      = done_q;
    assign err       = err_q;
    assign err_addr  = err_addr_q;
    assign ord_count = ord_count_q;

endmodule

// File: tb/tb_axil_order_sequencer.sv
// Directed + randomized bench: a delay-configurable AXI-lite slave responds to the
// sequencer, and each phase's observed writes/reads are compared with an order-list model.
module tb_axil_order_sequencer;

    localparam int         GAP   = 4;
    localparam logic [7:0] GATE  = 8'h48;
    localparam logic [7:0] STAT  = 8'h4c;
    localparam int         LIMIT = 3000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ord_valid = 1'b0, ord_ready, ord_last = 1'b0;
    logic [7:0]  ord_addr = '0;
    logic [31:0] ord_data = '0;
    logic [7:0]  awaddr, araddr, err_addr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        busy, done, err;
    logic [15:0] ord_count;

    always #5 clk = ~clk;

    axil_order_sequencer dut (
        .m00_axi_aclk(clk), .m00_axi_aresetn(rst_n),
        .ord_valid(ord_valid), .ord_ready(ord_ready), .ord_addr(ord_addr),
        .ord_data(ord_data), .ord_last(ord_last),
        .m00_axi_awaddr(awaddr), .m00_axi_awprot(awprot), .m00_axi_awvalid(awvalid),
        .m00_axi_awready(awready), .m00_axi_wdata(wdata), .m00_axi_wstrb(wstrb),
        .m00_axi_wvalid(wvalid), .m00_axi_wready(wready), .m00_axi_bresp(bresp),
        .m00_axi_bvalid(bvalid), .m00_axi_bready(bready), .m00_axi_araddr(araddr),
        .m00_axi_arprot(arprot), .m00_axi_arvalid(arvalid), .m00_axi_arready(arready),
        .m00_axi_rdata(rdata), .m00_axi_rresp(rresp), .m00_axi_rvalid(rvalid),
        .m00_axi_rready(rready),
        .busy(busy), .done(done), .err(err), .err_addr(err_addr), .ord_count(ord_count)
    );

    // ---------------- slave knobs (written by the stimulus only) ----------------
    int         aw_dly = 0, w_dly = 0;
    logic       b_stall = 1'b0;
    logic [1:0] resp_arr [128];
    logic [31:0] rd_arr  [128];

    // ---------------- monitor (posedge, sees pre-edge values) ----------------
    int          cyc = 0, nb_aw = 0, nb_w = 0, nb_b = 0, nb_ar = 0, nb_r = 0, done_cnt = 0;
    logic [7:0]  aw_q[$], ar_q[$];
    logic [31:0] w_q[$];
    int          aw_cyc[$], w_cyc[$], ar_cyc[$], ord_cyc[$];

    always @(posedge clk) begin
        if (!rst_n) begin
            cyc = 0; nb_aw = 0; nb_w = 0; nb_b = 0; nb_ar = 0; nb_r = 0; done_cnt = 0;
            aw_q.delete(); ar_q.delete(); w_q.delete();
            aw_cyc.delete(); w_cyc.delete(); ar_cyc.delete(); ord_cyc.delete();
        end else begin
            cyc++;
            if (ord_valid && ord_ready) ord_cyc.push_back(cyc);
            if (awvalid && awready) begin aw_q.push_back(awaddr); aw_cyc.push_back(cyc); nb_aw++; end
            if (wvalid && wready)   begin w_q.push_back(wdata);   w_cyc.push_back(cyc);  nb_w++;  end
            if (bvalid && bready)   nb_b++;
            if (arvalid && arready) begin ar_q.push_back(araddr); ar_cyc.push_back(cyc); nb_ar++; end
            if (rvalid && rready)   nb_r++;
            if (done) done_cnt++;
        end
    end

    // ---------------- slave responder (negedge) ----------------
    int aw_cnt = 0, w_cnt = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            awready = 0; wready = 0; bvalid = 0; bresp = 0;
            arready = 0; rvalid = 0; rdata = 0; rresp = 0; aw_cnt = 0; w_cnt = 0;
        end else begin
            if (awvalid) begin
                if (aw_cnt >= aw_dly) awready = 1; else begin awready = 0; aw_cnt++; end
            end else begin awready = 0; aw_cnt = 0; end
            if (wvalid) begin
                if (w_cnt >= w_dly) wready = 1; else begin wready = 0; w_cnt++; end
            end else begin wready = 0; w_cnt = 0; end
            bvalid  = (((nb_aw < nb_w) ? nb_aw : nb_w) > nb_b) && !b_stall;
            bresp   = resp_arr[nb_b % 128];
            arready = arvalid;
            rvalid  = (nb_ar > nb_r);
            rdata   = rd_arr[nb_r % 128];
            rresp   = 2'b00;
        end
    end

    // ---------------- reference model ----------------
    logic [7:0]  exp_addr[$];
    logic [31:0] exp_data[$];
    int          exp_writes = 0, exp_done = 0, wr_idx = 0;
    logic        exp_err = 0;
    logic [7:0]  exp_err_addr = '0;
    int          b_aw, b_w, b_ar, b_ord, b_b;

    int errors = 0, checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_bound(input string tag, input int n);
        checks++;
        assert (n < LIMIT) else begin
            errors++;
            $error("FAIL %s: waited %0d cycles, limit %0d", tag, n, LIMIT);
        end
    endtask

    task automatic snap();
        b_aw = aw_q.size(); b_w = w_q.size(); b_ar = ar_q.size();
        b_ord = ord_cyc.size(); b_b = nb_b;
        exp_addr.delete(); exp_data.delete();
    endtask

    // Called just after a negedge; returns just after the negedge following acceptance.
    task automatic push(input logic [7:0] a, input logic [31:0] d, input logic l, input logic [1:0] br);
        int n = 0;
        ord_valid = 1; ord_addr = a; ord_data = d; ord_last = l;
        while (!ord_ready && n < LIMIT) begin @(negedge clk); n++; end
        check_bound("push_wait", n);
        exp_addr.push_back(a); exp_data.push_back(d);
        resp_arr[wr_idx % 128] = br; wr_idx++;
        exp_writes++;
        if (l) exp_done++;
        if (br != 2'b00 && !exp_err) begin exp_err = 1; exp_err_addr = a; end
        @(negedge clk);
        ord_valid = 0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < LIMIT) begin @(negedge clk); n++; end
        check_bound({tag, "_idle"}, n);
        repeat (3) @(negedge clk);
    endtask

    task automatic compare(input string tag);
        check({tag, "_aw_n"}, aw_q.size() - b_aw, exp_addr.size());
        check({tag, "_w_n"},  w_q.size() - b_w,   exp_data.size());
        check({tag, "_b_n"},  nb_b - b_b,         exp_addr.size());
        for (int i = 0; i < exp_addr.size() && b_aw + i < aw_q.size(); i++)
            check($sformatf("%s_awaddr[%0d]", tag, i), aw_q[b_aw + i], exp_addr[i]);
        for (int i = 0; i < exp_data.size() && b_w + i < w_q.size(); i++)
            check($sformatf("%s_wdata[%0d]", tag, i), w_q[b_w + i], exp_data[i]);
        check({tag, "_ord_count"}, ord_count, exp_writes[15:0]);
        check({tag, "_done_cnt"}, done_cnt, exp_done);
        check({tag, "_err"}, err, exp_err);
        check({tag, "_err_addr"}, err_addr, exp_err_addr);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [7:0]  ra;
        logic [31:0] rd;
        for (int i = 0; i < 128; i++) begin resp_arr[i] = 2'b00; rd_arr[i] = 32'h1; end

        // ---- reset ----
        rst_n = 1; #1 rst_n = 0;
        repeat (3) @(negedge clk);
        check("rst_ord_ready", ord_ready, 0);
        check("rst_awvalid", awvalid, 0);
        check("rst_wvalid", wvalid, 0);
        check("rst_arvalid", arvalid, 0);
        check("rst_bready", bready, 0);
        check("rst_rready", rready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_err_addr", err_addr, 0);
        check("rst_ord_count", ord_count, 0);
        rst_n = 1;
        repeat (2) @(negedge clk);
        check("post_rst_ord_ready", ord_ready, 1);
        check("wstrb", wstrb, 4'hf);
        check("prot", {awprot, arprot}, 6'b0);

        // ---- three ungated orders, zero-wait slave ----
        snap();
        push(8'h00, 32'h1, 0, 2'b00);
        push(8'h04, 32'h2, 0, 2'b00);
        push(8'h08, 32'h3, 1, 2'b00);
        wait_idle("p1");
        compare("p1");
        if (aw_cyc.size() >= b_aw + 3 && ord_cyc.size() > b_ord) begin
            check("p1_latency", aw_cyc[b_aw] - ord_cyc[b_ord], 2);
            check("p1_period", (aw_cyc[b_aw + 1] - aw_cyc[b_aw]) <= 4, 1);
            check("p1_w_same_cycle", w_cyc[b_w], aw_cyc[b_aw]);
        end

        // ---- gated order, status 0,0,1 ----
        snap();
        rd_arr[nb_r % 128] = 0; rd_arr[(nb_r + 1) % 128] = 0; rd_arr[(nb_r + 2) % 128] = 1;
        push(GATE, 32'hA5, 1, 2'b00);
        wait_idle("p2");
        compare("p2");
        check("p2_ar_n", ar_q.size() - b_ar, 3);
        if (ar_q.size() >= b_ar + 3 && aw_cyc.size() > b_aw) begin
            for (int i = 0; i < 3; i++) check($sformatf("p2_araddr[%0d]", i), ar_q[b_ar + i], STAT);
            for (int i = 1; i < 3; i++)
                check($sformatf("p2_gap[%0d]", i), (ar_cyc[b_ar + i] - ar_cyc[b_ar + i - 1]) >= GAP + 1, 1);
            check("p2_write_after_ready", aw_cyc[b_aw] > ar_cyc[b_ar + 2], 1);
        end

        // ---- AW delayed 3, then W delayed 3 ----
        snap(); aw_dly = 3; w_dly = 0;
        push(8'h10, 32'h1111_0000, 0, 2'b00);
        wait_idle("p3a");
        compare("p3a");
        if (aw_cyc.size() > b_aw && w_cyc.size() > b_w) check("p3a_skew", aw_cyc[b_aw] - w_cyc[b_w], 3);
        snap(); aw_dly = 0; w_dly = 3;
        push(8'h14, 32'h2222_0000, 0, 2'b00);
        wait_idle("p3b");
        compare("p3b");
        if (aw_cyc.size() > b_aw && w_cyc.size() > b_w) check("p3b_skew", w_cyc[b_w] - aw_cyc[b_aw], 3);
        w_dly = 0;

        // ---- SLVERR on the second of three ----
        snap();
        push(8'h20, 32'hC0, 0, 2'b00);
        push(8'h24, 32'hC1, 0, 2'b10);
        push(8'h28, 32'hC2, 1, 2'b00);
        wait_idle("p4");
        compare("p4");

        // ---- randomized orders, delays and responses ----
        snap();
        aw_dly = $urandom_range(0, 2); w_dly = $urandom_range(0, 2);
        for (int i = 0; i < 12; i++) begin
            ra = 8'($urandom_range(0, 255));
            if (ra == GATE) ra = ra ^ 8'h01;
            rd = $urandom;
            push(ra, rd, i == 11, ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
        end
        wait_idle("p5");
        compare("p5");
        aw_dly = 0; w_dly = 0;

        // ---- 20 orders with B stalled ----
        snap(); b_stall = 1;
        for (int i = 0; i < 16; i++) push(8'(8'h80 + 4 * i), 32'(32'hD000 + i), 0, 2'b00);
        check("p6_ready_after_16", ord_ready, 1);
        push(8'hC0, 32'hD010, 0, 2'b00);
        check("p6_ready_after_17", ord_ready, 0);
        repeat (5) @(negedge clk);
        check("p6_ready_held", ord_ready, 0);
        check("p6_one_write_in_flight", aw_q.size() - b_aw, 1);
        b_stall = 0;
        for (int i = 17; i < 20; i++) push(8'(8'h80 + 4 * i), 32'(32'hD000 + i), i == 19, 2'b00);
        wait_idle("p6");
        compare("p6");

        // ---- reset during WR_REQ ----
        snap(); aw_dly = 6;
        push(8'h30, 32'hEE, 1, 2'b00);
        n = 0;
        while (!awvalid && n < LIMIT) begin @(negedge clk); n++; end
        check_bound("p7_wait_awvalid", n);
        #2 rst_n = 0;
        #1;
        check("p7_rst_awvalid", awvalid, 0);
        check("p7_rst_wvalid", wvalid, 0);
        check("p7_rst_bready", bready, 0);
        check("p7_rst_ord_ready", ord_ready, 0);
        check("p7_rst_busy", busy, 0);
        check("p7_rst_err", err, 0);
        check("p7_rst_ord_count", ord_count, 0);
        exp_writes = 0; exp_done = 0; exp_err = 0; exp_err_addr = '0; wr_idx = 0;
        for (int i = 0; i < 128; i++) begin resp_arr[i] = 2'b00; rd_arr[i] = 32'h1; end
        repeat (2) @(negedge clk);
        rst_n = 1; aw_dly = 0;
        repeat (2) @(negedge clk);
        check("p7_ready_again", ord_ready, 1);
        snap();
        push(8'h34, 32'h5A5A, 1, 2'b00);
        wait_idle("p7");
        compare("p7");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
